// File: rtl/ddc_tune_ctrl_if.sv
// Host-config, ddc-control and sample buses of the ddc retune sequencer.
// The sequencer uses the slave modport; the host/ddc side uses master.
interface ddc_tune_ctrl_if #(
    parameter int FSZ = 26,
    parameter int OSZ = 16
);
    logic           cfg_valid;
    logic           cfg_ready;
    logic [FSZ-1:0] cfg_freq;
    logic           cfg_ns_en;
    logic           cfg_iq_swap;

    logic           ddc_reset;
    logic [FSZ-1:0] ddc_lo_freq;
    logic           ddc_lo_ns_en;
    logic           ddc_iq_swap;
    logic           ddc_valid;
    logic [OSZ-1:0] ddc_i;
    logic [OSZ-1:0] ddc_q;

    logic           out_valid;
    logic [OSZ-1:0] out_i;
    logic [OSZ-1:0] out_q;

    modport slave (
        input  cfg_valid, cfg_freq, cfg_ns_en, cfg_iq_swap,
        input  ddc_valid, ddc_i, ddc_q,
        output cfg_ready, ddc_reset, ddc_lo_freq, ddc_lo_ns_en, ddc_iq_swap,
        output out_valid, out_i, out_q
    );

    modport master (
        output cfg_valid, cfg_freq, cfg_ns_en, cfg_iq_swap,
        output ddc_valid, ddc_i, ddc_q,
        input  cfg_ready, ddc_reset, ddc_lo_freq, ddc_lo_ns_en, ddc_iq_swap,
        input  out_valid, out_i, out_q
    );
endinterface

// File: rtl/ddc_tune_ctrl.sv
// Retune sequencer: applies host tuning requests to the ddc, resets it when
// filter state is invalid and blanks unsettled samples. Optional counters: DDC_TUNE_CTRL_STATS_EN.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_INIT  | post-reset: hold ddc_reset for RST_CYC cycles
//   S_IDLE  | ready for requests, samples pass through
//   S_RST   | ns_en/iq_swap changed: hold ddc_reset for RST_CYC cycles
//   S_FLUSH | discard SETTLE ddc_valid samples
module ddc_tune_ctrl #(
    parameter int FSZ     = 26,
    parameter int OSZ     = 16,
    parameter int SETTLE  = 8,
    parameter int RST_CYC = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    ddc_tune_ctrl_if.slave  bus,
    output logic            busy
`ifdef DDC_TUNE_CTRL_STATS_EN
    ,
    output logic [15:0]     stat_retunes,
    output logic [15:0]     stat_drops
`endif
);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_RST   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    localparam logic [3:0] RST_LAST    = 4'(RST_CYC - 1);
    localparam logic [7:0] SETTLE_LAST = (SETTLE == 0) ? 8'd0 : 8'(SETTLE - 1);
    // With no blanking the reset pulse leads straight back to IDLE.
    localparam state_t     POST_RST    = (SETTLE == 0) ? S_IDLE : S_FLUSH;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] rst_cnt;
    logic [7:0] settle_cnt;

    logic accept;
    logic mode_chg;
    logic freq_chg;
    logic rst_done;
    logic settle_done;
    logic in_idle;

    assign in_idle     = (state == S_IDLE);
    assign accept      = in_idle & bus.cfg_valid & bus.cfg_ready;
    assign mode_chg    = (bus.cfg_ns_en != bus.ddc_lo_ns_en) | (bus.cfg_iq_swap != bus.ddc_iq_swap);
    assign freq_chg    = (bus.cfg_freq != bus.ddc_lo_freq);
    assign rst_done    = (rst_cnt == RST_LAST);
    assign settle_done = bus.ddc_valid & (settle_cnt == SETTLE_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_INIT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT, S_RST: if (rst_done) state_nxt = POST_RST;
            S_IDLE: begin
                if (accept) begin
                    if (mode_chg)      state_nxt = S_RST;
                    else if (freq_chg) state_nxt = POST_RST;
                end
            end
            S_FLUSH: if (settle_done) state_nxt = S_IDLE;
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_cnt    <= 4'd0;
            settle_cnt <= 8'd0;
        end else begin
            if ((state == S_INIT || state == S_RST) && !rst_done) rst_cnt <= rst_cnt + 4'd1;
            else                                                  rst_cnt <= 4'd0;
            if (state == S_FLUSH && bus.ddc_valid)
                settle_cnt <= settle_done ? 8'd0 : settle_cnt + 8'd1;
        end
    end

    assign bus.ddc_reset = (state == S_INIT) || (state == S_RST);
    assign busy          = !in_idle;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.cfg_ready    <= 1'b0;
            bus.ddc_lo_freq  <= '0;
            bus.ddc_lo_ns_en <= 1'b0;
            bus.ddc_iq_swap  <= 1'b0;
        end else begin
            bus.cfg_ready <= (state_nxt == S_IDLE);
            if (accept) begin
                bus.ddc_lo_freq  <= bus.cfg_freq;
                bus.ddc_lo_ns_en <= bus.cfg_ns_en;
                bus.ddc_iq_swap  <= bus.cfg_iq_swap;
            end
        end
    end

    // A sample arriving with an accept still belongs to the old config and passes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.out_valid <= 1'b0;
            bus.out_i     <= '0;
            bus.out_q     <= '0;
        end else begin
            bus.out_valid <= in_idle & bus.ddc_valid;
            if (in_idle && bus.ddc_valid) begin
                bus.out_i <= bus.ddc_i;
                bus.out_q <= bus.ddc_q;
            end
        end
    end

`ifdef DDC_TUNE_CTRL_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_retunes <= 16'd0;
            stat_drops   <= 16'd0;
        end else begin
            if (accept && (mode_chg || freq_chg) && stat_retunes != 16'hFFFF)
                stat_retunes <= stat_retunes + 16'd1;
            if (state == S_FLUSH && bus.ddc_valid && stat_drops != 16'hFFFF)
                stat_drops <= stat_drops + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ddc_tune_ctrl.sv
// Scoreboard bench for ddc_tune_ctrl: a counter-based reference model predicts
// control outputs each cycle and queues expected samples for a separate monitor.
module tb_ddc_tune_ctrl;
    localparam int FSZ     = 26;
    localparam int OSZ     = 16;
    localparam int SETTLE  = 8;
    localparam int RST_CYC = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic busy;
`ifdef DDC_TUNE_CTRL_STATS_EN
    logic [15:0] stat_retunes;
    logic [15:0] stat_drops;
`endif

    always #5 clk = ~clk;

    ddc_tune_ctrl_if #(.FSZ(FSZ), .OSZ(OSZ)) bus ();

    ddc_tune_ctrl #(.FSZ(FSZ), .OSZ(OSZ), .SETTLE(SETTLE), .RST_CYC(RST_CYC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .busy        (busy)
`ifdef DDC_TUNE_CTRL_STATS_EN
        ,
        .stat_retunes(stat_retunes),
        .stat_drops  (stat_drops)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference model: remaining reset cycles, remaining samples to blank, applied config.
    int             m_rst_left;
    int             m_drop_left;
    logic [FSZ-1:0] m_freq;
    logic           m_ns;
    logic           m_swap;
    int             m_retunes;
    int             m_drops;
    logic [2*OSZ-1:0] exp_q[$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit model_idle();
        return (m_rst_left == 0) && (m_drop_left == 0);
    endfunction

    function automatic void model_reset();
        m_rst_left  = RST_CYC;
        m_drop_left = 0;
        m_freq      = '0;
        m_ns        = 1'b0;
        m_swap      = 1'b0;
        m_retunes   = 0;
        m_drops     = 0;
        exp_q.delete();
    endfunction

    function automatic void model_step(logic cv, logic [FSZ-1:0] f, logic ns, logic sw,
                                       logic dv, logic [OSZ-1:0] di, logic [OSZ-1:0] dq);
        if (m_rst_left > 0) begin
            m_rst_left--;
            if (m_rst_left == 0) m_drop_left = SETTLE;
        end else if (m_drop_left > 0) begin
            if (dv) begin
                m_drop_left--;
                if (m_drops < 65535) m_drops++;
            end
        end else begin
            if (dv) exp_q.push_back({di, dq});
            if (cv) begin
                if (ns != m_ns || sw != m_swap) begin
                    m_rst_left = RST_CYC;
                    if (m_retunes < 65535) m_retunes++;
                end else if (f != m_freq) begin
                    m_drop_left = SETTLE;
                    if (m_retunes < 65535) m_retunes++;
                end
                m_freq = f;
                m_ns   = ns;
                m_swap = sw;
            end
        end
    endfunction

    function automatic void check_ctrl();
        chk("cfg_ready", bus.cfg_ready, model_idle());
        chk("busy", busy, !model_idle());
        chk("ddc_reset", bus.ddc_reset, m_rst_left > 0);
        chk("ddc_lo_freq", bus.ddc_lo_freq, m_freq);
        chk("ddc_lo_ns_en", bus.ddc_lo_ns_en, m_ns);
        chk("ddc_iq_swap", bus.ddc_iq_swap, m_swap);
`ifdef DDC_TUNE_CTRL_STATS_EN
        chk("stat_retunes", stat_retunes, 16'(m_retunes));
        chk("stat_drops", stat_drops, 16'(m_drops));
`endif
    endfunction

    task automatic step(input logic cv, input logic [FSZ-1:0] f, input logic ns, input logic sw,
                        input logic dv, input logic [OSZ-1:0] di, input logic [OSZ-1:0] dq);
        bus.cfg_valid   = cv;
        bus.cfg_freq    = f;
        bus.cfg_ns_en   = ns;
        bus.cfg_iq_swap = sw;
        bus.ddc_valid   = dv;
        bus.ddc_i       = di;
        bus.ddc_q       = dq;
        @(posedge clk);
        model_step(cv, f, ns, sw, dv, di, dq);
        @(negedge clk);
        check_ctrl();
    endtask

    // Entered with reset_n low: hold it, release, and replay the slow startup.
    task automatic startup();
        int rc;
        model_reset();
        bus.cfg_valid = 1'b0;
        bus.ddc_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_i", bus.out_i, '0);
        chk("rst_out_q", bus.out_q, '0);
        chk("rst_ddc_reset", bus.ddc_reset, 1'b1);
        chk("rst_cfg_ready", bus.cfg_ready, 1'b0);
        chk("rst_busy", busy, 1'b1);
        reset_n = 1'b1;
        check_ctrl();
        rc = bus.ddc_reset ? 1 : 0;
        for (int c = 1; c <= 9 * 32 + 3; c++) begin
            step(1'b0, '0, 1'b0, 1'b0, (c % 32) == 0, OSZ'(c), OSZ'(c ^ 16'h00FF));
            if (bus.ddc_reset) rc++;
        end
        chk("init_reset_len", rc, RST_CYC);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a sample.
    initial begin
        logic [2*OSZ-1:0] e;
        forever begin
            @(negedge clk);
            if (reset_n && bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected actual=%0h required=none at %0t",
                             {bus.out_i, bus.out_q}, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_iq", {bus.out_i, bus.out_q}, e);
                end
            end
        end
    end

    initial begin
        logic           have_req;
        logic           pre_idle;
        logic [FSZ-1:0] r_freq;
        logic           r_ns;
        logic           r_sw;
        logic           dv;

        bus.cfg_valid   = 1'b0;
        bus.cfg_freq    = '0;
        bus.cfg_ns_en   = 1'b0;
        bus.cfg_iq_swap = 1'b0;
        bus.ddc_valid   = 1'b0;
        bus.ddc_i       = '0;
        bus.ddc_q       = '0;

        startup();

        // Freq-only retune: no ddc reset, 8 samples blanked.
        step(1'b1, 26'h0400000, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int c = 1; c <= 40; c++)
            step(1'b0, 26'h0400000, 1'b0, 1'b0, (c % 4) == 0, OSZ'(c + 100), OSZ'(c));

        // IQ swap change: reset pulse with ignored samples, then blanking.
        step(1'b1, 26'h0400000, 1'b0, 1'b1, 1'b0, '0, '0);
        for (int c = 1; c <= 30; c++)
            step(1'b0, 26'h0400000, 1'b0, 1'b1, (c % 2) == 0, OSZ'(c + 200), OSZ'(c));

        // Identical request with a sample in the same cycle.
        step(1'b1, 26'h0400000, 1'b0, 1'b1, 1'b1, 16'hAAAA, 16'h5555);
        for (int c = 1; c <= 4; c++)
            step(1'b0, 26'h0400000, 1'b0, 1'b1, (c % 2) == 0, OSZ'(c + 300), OSZ'(c));

        // Accept and sample together: sample passes, following ones blanked.
        step(1'b1, 26'h0123456, 1'b0, 1'b1, 1'b1, 16'h1234, 16'h5678);
        for (int c = 1; c <= 30; c++)
            step(1'b0, 26'h0123456, 1'b0, 1'b1, (c % 3) == 0, OSZ'(c + 400), OSZ'(c));

        // Reset asserted mid-flush.
        step(1'b1, 26'h2AAAAAA, 1'b1, 1'b1, 1'b0, '0, '0);
        for (int c = 1; c <= 10; c++)
            step(1'b0, 26'h2AAAAAA, 1'b1, 1'b1, 1'b1, OSZ'(c + 500), OSZ'(c));
        chk("pre_abort_busy", busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid, 1'b0);
        chk("abort_ddc_reset", bus.ddc_reset, 1'b1);
        chk("abort_lo_freq", bus.ddc_lo_freq, '0);
        chk("abort_cfg_ready", bus.cfg_ready, 1'b0);
`ifdef DDC_TUNE_CTRL_STATS_EN
        chk("abort_stat_retunes", stat_retunes, 16'd0);
        chk("abort_stat_drops", stat_drops, 16'd0);
`endif
        startup();

        // Randomized phase: requester holds each request until accepted.
        have_req = 1'b0;
        r_freq   = '0;
        r_ns     = 1'b0;
        r_sw     = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (!have_req && $urandom_range(0, 3) == 0) begin
                have_req = 1'b1;
                r_freq   = m_freq;
                r_ns     = m_ns;
                r_sw     = m_swap;
                case ($urandom_range(0, 3))
                    0: ;
                    1: r_freq = FSZ'($urandom());
                    2: r_sw = ~r_sw;
                    default: begin
                        r_ns = ~r_ns;
                        if ($urandom_range(0, 1) == 1) r_freq = FSZ'($urandom());
                    end
                endcase
            end
            dv = ($urandom_range(0, 2) == 0);
            pre_idle = model_idle();
            step(have_req, r_freq, r_ns, r_sw, dv, OSZ'($urandom()), OSZ'($urandom()));
            if (have_req && pre_idle) have_req = 1'b0;
        end

        for (int c = 0; c < 4; c++)
            step(1'b0, r_freq, r_ns, r_sw, 1'b0, '0, '0);
        chk("queue_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
